queue_reader: RTL

QUEUE_READER -- requirements
Module: queue_reader

---
 rtl/queue_reader.sv | 74 +++++++
 1 files changed

// File: rtl/queue_reader.sv
// Drains a queue one entry at a time and forwards each entry downstream over a valid/ready handshake.
// Dequeue-to-out_valid latency is 2 cycles; out_data holds indefinitely while out_ready stays low.
module queue_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] max_count,
  input  logic       q_nonempty,
  output logic       q_dequeue,
  input  logic [7:0] q_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] count
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, FINISH} state_t;

  state_t     state;
  logic [7:0] limit;
  logic [7:0] outData;
  logic [7:0] cnt;
  logic [7:0] cntInc;

  assign cntInc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      limit   <= 8'h00;
      outData <= 8'h00;
      cnt     <= 8'h00;
    end else if (abort && state != IDLE) begin
      // Abort wins over every other transition; the captured item is discarded.
      state   <= IDLE;
      outData <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= FETCH;
            limit <= max_count;
            cnt   <= 8'h00;
          end
        end
        FETCH:   state <= q_nonempty ? CAPTURE : FINISH;
        CAPTURE: begin
          outData <= q_data;
          state   <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            cnt   <= cntInc;
            state <= (limit != 8'h00 && cntInc == limit) ? FINISH : FETCH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The dequeue must fire in the same FETCH cycle that samples q_nonempty.
  assign q_dequeue = (state == FETCH) && q_nonempty;
  assign out_valid = (state == SEND);
  assign out_data  = outData;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign count     = cnt;

endmodule
